// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: HDMI data-island packet codes and the per-slot priority decode shared by the scheduler.
package hdmi_packet_pkg;
  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_SPD   = 8'h83;
  localparam logic [7:0] PKT_AIF   = 8'h84;
  typedef enum logic [2:0] {
    KIND_NULL,
    KIND_ACR,
    KIND_AVI,
    KIND_AIF,
    KIND_SPD,
    KIND_AUDIO
  } packet_kind_t;
  typedef struct packed {
    logic acr;
    logic avi;
    logic aif;
    logic spd;
  } due_flags_t;
  // spd in flags must already be qualified by spd_enable
  function automatic packet_kind_t next_packet(input due_flags_t flags, input logic remaining_nonzero);
    return flags.acr ? KIND_ACR :
           flags.avi ? KIND_AVI :
           flags.aif ? KIND_AIF :
           flags.spd ? KIND_SPD :
           remaining_nonzero ? KIND_AUDIO : KIND_NULL;
  endfunction
  function automatic logic [7:0] kind_code(input packet_kind_t kind);
    return kind == KIND_ACR   ? PKT_ACR :
           kind == KIND_AVI   ? PKT_AVI :
           kind == KIND_AIF   ? PKT_AIF :
           kind == KIND_SPD   ? PKT_SPD :
           kind == KIND_AUDIO ? PKT_AUDIO : PKT_NULL;
  endfunction
endpackage

// File: rtl/packet_scheduler_if.sv
// packet_scheduler_if: packet slot handshake (hdmi side) and audio buffer handshake.
//   packet_enable : slot offered by hdmi       packet_type : chosen packet type
//   remaining     : audio buffer occupancy     audio_pop   : buffer advance strobe
//   master = hdmi core / audio buffer side, slave = scheduler
interface packet_scheduler_if #(parameter int AUDIO_REMAINING_WIDTH = 7) ();
  logic packet_enable;
  logic [7:0] packet_type;
  logic [AUDIO_REMAINING_WIDTH-1:0] remaining;
  logic audio_pop;
  modport master (output packet_enable, remaining, input packet_type, audio_pop);
  modport slave (input packet_enable, remaining, output packet_type, audio_pop);
endinterface

// File: rtl/packet_scheduler.sv
// packet_scheduler: picks the HDMI data-island packet type for each offered slot.
//   clk_pixel, reset (async, active-high) ; frame_start : start-of-frame pulse
//   spd_enable : permits SPD InfoFrames ; bus : slot/audio handshake (slave)
//   audio_packets_last_frame : audio packets issued in the previous frame
module packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int AUDIO_REMAINING_WIDTH = 7,
  parameter int SPD_PERIOD = 60
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic frame_start,
  input  logic spd_enable,
  packet_scheduler_if.slave bus,
  output logic [7:0] audio_packets_last_frame
);
  due_flags_t due, armed, due_d;
  packet_kind_t kind;
  logic [7:0] frame_count, frame_count_d, audio_count, count_base, audio_count_d;
  logic spd_wrap, take, audio_inc;
  // frame_start re-arms the flags before the same-cycle slot is arbitrated
  always_comb begin
    spd_wrap = frame_start && frame_count == 8'(SPD_PERIOD - 1);
    armed = '{acr: due.acr | frame_start, avi: due.avi | frame_start, aif: due.aif | frame_start,
              spd: due.spd | (spd_wrap & spd_enable)};
    kind = next_packet('{acr: armed.acr, avi: armed.avi, aif: armed.aif, spd: armed.spd & spd_enable},
                       bus.remaining != AUDIO_REMAINING_WIDTH'(0));
    take = bus.packet_enable;
    due_d = '{acr: armed.acr & ~(take && kind == KIND_ACR), avi: armed.avi & ~(take && kind == KIND_AVI),
              aif: armed.aif & ~(take && kind == KIND_AIF), spd: armed.spd & ~(take && kind == KIND_SPD)};
    audio_inc = take && kind == KIND_AUDIO;
    count_base = frame_start ? 8'd0 : audio_count;
    audio_count_d = count_base + {7'd0, audio_inc && count_base != 8'hff};
    frame_count_d = frame_start ? (spd_wrap ? 8'd0 : frame_count + 8'd1) : frame_count;
  end
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      due <= '0;
      frame_count <= '0;
      audio_count <= '0;
      audio_packets_last_frame <= '0;
      bus.packet_type <= PKT_NULL;
      bus.audio_pop <= 1'b0;
    end else begin
      due <= due_d;
      frame_count <= frame_count_d;
      audio_count <= audio_count_d;
      if (frame_start) audio_packets_last_frame <= audio_count;
      if (take) bus.packet_type <= kind_code(kind);
      bus.audio_pop <= audio_inc;
    end
  end
endmodule

// File: tb/tb_packet_scheduler.sv
// tb_packet_scheduler: directed self-checking bench for packet_scheduler (SPD_PERIOD=2).
module tb_packet_scheduler;
  logic clk = 0, reset = 1, frame_start = 0, spd_enable = 0;
  logic [7:0] last;
  int passed = 0, total = 0, pops = 0;
  packet_scheduler_if #(.AUDIO_REMAINING_WIDTH(7)) bus ();
  packet_scheduler #(.AUDIO_REMAINING_WIDTH(7), .SPD_PERIOD(2)) dut (
    .clk_pixel(clk), .reset(reset), .frame_start(frame_start), .spd_enable(spd_enable),
    .bus(bus), .audio_packets_last_frame(last));
  always #5 clk = ~clk;
  always @(posedge clk) pops <= pops + int'(bus.audio_pop);

  task automatic slot(input logic [6:0] rem);
    @(negedge clk); bus.packet_enable = 1; bus.remaining = rem;
    @(negedge clk); bus.packet_enable = 0;
  endtask

  task automatic frame();
    @(negedge clk); frame_start = 1;
    @(negedge clk); frame_start = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.packet_type !== 8'h00) $display("FAIL reset_type got %h want 00", bus.packet_type); else passed++;
    total++; if (bus.audio_pop !== 1'b0) $display("FAIL reset_pop got %b want 0", bus.audio_pop); else passed++;
    total++; if (last !== 8'd0) $display("FAIL reset_last got %0d want 0", last); else passed++;
    reset = 0;
    slot(7'd3);
    total++; if (bus.packet_type !== 8'h02) $display("FAIL reset_no_acr got %h want 02", bus.packet_type); else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] exp [6] = '{8'h01, 8'h82, 8'h84, 8'h02, 8'h02, 8'h02};
    int base;
    frame();
    base = pops;
    for (int i = 0; i < 6; i++) begin
      slot(7'd3);
      total++; if (bus.packet_type !== exp[i]) $display("FAIL basic_type[%0d] got %h want %h", i, bus.packet_type, exp[i]); else passed++;
      total++; if (bus.audio_pop !== (i >= 3)) $display("FAIL basic_pop[%0d] got %b want %b", i, bus.audio_pop, i >= 3); else passed++;
    end
    @(negedge clk);
    total++; if (pops - base !== 3) $display("FAIL basic_pop_count got %0d want 3", pops - base); else passed++;
  endtask

  task automatic test_null();
    int base = pops;
    for (int i = 0; i < 4; i++) begin
      slot(7'd0);
      total++; if (bus.packet_type !== 8'h00) $display("FAIL null_type[%0d] got %h want 00", i, bus.packet_type); else passed++;
    end
    @(negedge clk);
    total++; if (pops - base !== 0) $display("FAIL null_pop_count got %0d want 0", pops - base); else passed++;
  endtask

  task automatic test_audio_count();
    frame();
    total++; if (last !== 8'd3) $display("FAIL count_3 got %0d want 3", last); else passed++;
    repeat (3) slot(7'd0);
    repeat (10) slot(7'd5);
    frame();
    total++; if (last !== 8'd10) $display("FAIL count_10 got %0d want 10", last); else passed++;
    repeat (3) slot(7'd0);
    repeat (300) slot(7'd5);
    frame();
    total++; if (last !== 8'd255) $display("FAIL count_sat got %0d want 255", last); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp [4] = '{8'h82, 8'h84, 8'h02, 8'h02};
    repeat (3) slot(7'd0);
    repeat (4) slot(7'd1);
    @(negedge clk); frame_start = 1; bus.packet_enable = 1; bus.remaining = 7'd3;
    @(negedge clk); frame_start = 0; bus.packet_enable = 0;
    total++; if (bus.packet_type !== 8'h01) $display("FAIL simul_type got %h want 01", bus.packet_type); else passed++;
    total++; if (last !== 8'd4) $display("FAIL simul_last got %0d want 4", last); else passed++;
    for (int i = 0; i < 4; i++) begin
      slot(7'd3);
      total++; if (bus.packet_type !== exp[i]) $display("FAIL simul_seq[%0d] got %h want %h", i, bus.packet_type, exp[i]); else passed++;
    end
    frame();
    total++; if (last !== 8'd2) $display("FAIL simul_next_last got %0d want 2", last); else passed++;
  endtask

  task automatic test_spd();
    logic [7:0] exp;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; spd_enable = 1;
    for (int f = 1; f <= 4; f++) begin
      frame();
      for (int s = 0; s < 5; s++) begin
        slot(7'd0);
        exp = s == 0 ? 8'h01 : s == 1 ? 8'h82 : s == 2 ? 8'h84 : (s == 3 && f % 2 == 0) ? 8'h83 : 8'h00;
        total++; if (bus.packet_type !== exp) $display("FAIL spd_f%0d_s%0d got %h want %h", f, s, bus.packet_type, exp); else passed++;
      end
    end
  endtask

  task automatic test_spd_hold();
    logic [7:0] exp [4] = '{8'h01, 8'h82, 8'h84, 8'h00};
    frame();
    for (int i = 0; i < 4; i++) begin
      slot(7'd0);
      total++; if (bus.packet_type !== exp[i]) $display("FAIL hold_f5[%0d] got %h want %h", i, bus.packet_type, exp[i]); else passed++;
    end
    frame();
    spd_enable = 0;
    for (int i = 0; i < 4; i++) begin
      slot(7'd0);
      total++; if (bus.packet_type !== exp[i]) $display("FAIL hold_off[%0d] got %h want %h", i, bus.packet_type, exp[i]); else passed++;
    end
    spd_enable = 1;
    slot(7'd0);
    total++; if (bus.packet_type !== 8'h83) $display("FAIL hold_resume got %h want 83", bus.packet_type); else passed++;
    slot(7'd0);
    total++; if (bus.packet_type !== 8'h00) $display("FAIL hold_once got %h want 00", bus.packet_type); else passed++;
    spd_enable = 0;
  endtask

  task automatic test_reset_mid();
    int base;
    frame();
    repeat (3) slot(7'd0);
    total++; if (bus.packet_type !== 8'h84) $display("FAIL mid_pre got %h want 84", bus.packet_type); else passed++;
    base = pops;
    @(negedge clk); bus.packet_enable = 1; bus.remaining = 7'd3;
    #2 reset = 1;
    #1;
    total++; if (bus.packet_type !== 8'h00) $display("FAIL mid_async got %h want 00", bus.packet_type); else passed++;
    @(negedge clk); bus.packet_enable = 0; reset = 0;
    total++; if (bus.audio_pop !== 1'b0) $display("FAIL mid_pop got %b want 0", bus.audio_pop); else passed++;
    total++; if (last !== 8'd0) $display("FAIL mid_last got %0d want 0", last); else passed++;
    @(negedge clk);
    total++; if (pops - base !== 0) $display("FAIL mid_pop_count got %0d want 0", pops - base); else passed++;
    slot(7'd0);
    total++; if (bus.packet_type !== 8'h00) $display("FAIL mid_no_acr got %h want 00", bus.packet_type); else passed++;
    slot(7'd3);
    total++; if (bus.packet_type !== 8'h02) $display("FAIL mid_audio got %h want 02", bus.packet_type); else passed++;
    frame();
    slot(7'd0);
    total++; if (bus.packet_type !== 8'h01) $display("FAIL mid_acr got %h want 01", bus.packet_type); else passed++;
  endtask

  initial begin
    bus.packet_enable = 0;
    bus.remaining = '0;
    test_reset();
    test_basic();
    test_null();
    test_audio_count();
    test_simultaneous();
    test_spd();
    test_spd_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
